led_pattern_sequencer: RTL and testbench
========================================

Name: led_pattern_sequencer

Overview:
- Sequences the 8-bit motor status LED bank: converts mode requests from the motor control logic or STM32 register interface into timed LED patterns (off, steady, blink, chase).
- Fault indication has priority over normal requests.
- Sits between the motor controller and the LED pins. It replaces direct static drive of the bank with a clocked pattern generator that has a valid/ready request port.

Parameters:
- TICK_DIV, 50000, clk cycles per base tick (1 ms at 50 MHz); must be >= 2.
- STEP_TICKS, 100, base ticks per pattern step; must be >= 1.
- CNT_W, 16, width of both internal counters; must hold TICK_DIV-1 and STEP_TICKS-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- mode_req  in  2  requested mode: 0 OFF, 1 ON, 2 BLINK, 3 CHASE.
- mode_valid  in  1  request strobe.
- mode_ready  out  1  request can be accepted this cycle (combinational).
- dir  in  1  chase direction: 1 = left (bit0 toward bit7), 0 = right; sampled at each step.
- fault  in  1  motor fault, level, asynchronous to the request port but synchronous to clk.
- fault_clr  in  1  single-cycle pulse that clears a latched fault.
- led  out  8  LED drive, registered.
- mode_cur  out  2  currently active mode, registered.
- in_fault  out  1  fault latched / FAULT state active, registered.

Behaviour:
- Reset values: led=8'h00, mode_cur=0 (OFF), in_fault=0, state=NORMAL, tick_cnt=0, step_cnt=0, blink phase=0.
- Clock and reset are decided: one clock `clk`; reset is synchronous and active-high, named `reset`.
- Reset dominates all other inputs in the same cycle.
- Tick counter:
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - tick is high in the cycle tick_cnt==TICK_DIV-1.
- Step counter:
  - Advances on tick, counting 0..STEP_TICKS-1 and wrapping.
  - step is high when tick && step_cnt==STEP_TICKS-1.
  - Steps occur every TICK_DIV*STEP_TICKS cycles.
- FSM states: NORMAL, FAULT.
- mode_ready = (state==NORMAL) && !fault.
- Request acceptance happens when mode_valid && mode_ready:
  - mode_cur <= mode_req.
  - tick_cnt and step_cnt clear to 0.
  - The first pattern value appears on led the cycle after acceptance (1-cycle latency).
- First pattern value on acceptance:
  - OFF: 8'h00.
  - ON: 8'hFF.
  - BLINK: 8'hFF.
  - CHASE: 8'h01 if dir=1, 8'h80 if dir=0.
- NORMAL operation on each step:
  - OFF and ON: held, no change.
  - BLINK: toggles between 8'hFF and 8'h00.
  - CHASE: one-hot rotate by 1 (left if dir=1, right if dir=0); wraps bit7->bit0 and bit0->bit7.
  - No change between steps.
- Re-requesting the current mode is accepted and restarts its pattern and counters.
- NORMAL->FAULT when fault=1 in any cycle:
  - in_fault<=1, led<=8'h55, counters clear, blink phase=0.
  - mode_cur is unchanged; it is held for diagnostics.
  - A request in the same cycle is not accepted because mode_ready=0.
- FAULT operation:
  - led alternates 8'h55/8'hAA on each step.
  - Further fault assertions have no effect.
  - mode_valid is ignored (mode_ready=0).
- FAULT->NORMAL only on fault_clr=1 with fault=0 in the same cycle:
  - in_fault<=0, mode_cur<=0, led<=8'h00, counters clear.
- fault_clr while fault=1: ignored; remain in FAULT.
- fault_clr in NORMAL: no effect.
- Reset mid-pattern or mid-fault returns all outputs to their reset values the next cycle, and the fault latch is cleared.

Test Plan:
Bench parameters: TICK_DIV=4, STEP_TICKS=2, so one step = 8 clk cycles.
1. Reset held 3 cycles, then released with no request -> led=00, mode_cur=0, in_fault=0, mode_ready=1; led stays 00 for 50 cycles.
2. Accept BLINK (mode_req=2, valid 1 cycle) -> led=FF the next cycle; then 00 at +8 cycles, FF at +16, 00 at +24.
3. Accept CHASE with dir=1 -> led sequence 01,02,04,...,80,01 at 8-cycle spacing. Flip dir to 0 while led=04 -> next step 02. A 16-step run checks both wraps.
4. During ON, assert fault for 1 cycle while mode_valid=1 with mode_req=3 -> mode_ready=0 that cycle, request not accepted. Next cycle led=55, in_fault=1, mode_cur=1. Then led=AA at +8, 55 at +16.
5. In FAULT, pulse fault_clr while fault=1 -> still FAULT. Drop fault, pulse fault_clr -> next cycle led=00, mode_cur=0, in_fault=0, mode_ready=1. Then accept ON -> led=FF.
6. Mid-CHASE (led=10), assert reset for 1 cycle -> next cycle led=00, mode_cur=0. A new BLINK request is accepted on the first cycle after reset deasserts.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// Motor status LED bank sequencer: turns accepted mode requests into timed
// OFF/ON/BLINK/CHASE patterns, with a latched fault display taking priority.
module led_pattern_sequencer #(
    parameter int TICK_DIV   = 50000,
    parameter int STEP_TICKS = 100,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode_req,
    input  logic       mode_valid,
    output logic       mode_ready,
    input  logic       dir,
    input  logic       fault,
    input  logic       fault_clr,
    output logic [7:0] led,
    output logic [1:0] mode_cur,
    output logic       in_fault
);

    // Request handshake: a request transfers in a cycle where mode_valid and
    // mode_ready are both high; mode_ready is low in FAULT or while fault is high.
    typedef enum logic {
        NORMAL = 1'b0,
        FAULT  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_TICKS - 1);

    state_t           state;
    logic [CNT_W-1:0] tick_cnt;
    logic [CNT_W-1:0] step_cnt;
    logic             phase;
    logic             tick;
    logic             step;
    logic             accept;

    assign tick       = (tick_cnt == TICK_LAST);
    assign step       = tick && (step_cnt == STEP_LAST);
    assign mode_ready = (state == NORMAL) && !fault;
    assign accept     = mode_valid && mode_ready;

    function automatic logic [7:0] first_led(input logic [1:0] m, input logic d);
        case (m)
            2'd0:    first_led = 8'h00;
            2'd3:    first_led = d ? 8'h01 : 8'h80;
            default: first_led = 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= NORMAL;
            led      <= 8'h00;
            mode_cur <= 2'd0;
            in_fault <= 1'b0;
            tick_cnt <= '0;
            step_cnt <= '0;
            phase    <= 1'b0;
        end else begin
            // Free-running timebase; restart events below override it.
            if (tick) begin
                tick_cnt <= '0;
                step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + CNT_W'(1);
            end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end

            case (state)
                NORMAL: begin
                    if (fault) begin
                        state    <= FAULT;
                        in_fault <= 1'b1;
                        led      <= 8'h55;
                        tick_cnt <= '0;
                        step_cnt <= '0;
                        phase    <= 1'b0;
                    end else if (accept) begin
                        mode_cur <= mode_req;
                        led      <= first_led(mode_req, dir);
                        tick_cnt <= '0;
                        step_cnt <= '0;
                        phase    <= 1'b0;
                    end else if (step) begin
                        case (mode_cur)
                            2'd2: begin
                                led   <= phase ? 8'hFF : 8'h00;
                                phase <= ~phase;
                            end
                            2'd3: led <= dir ? {led[6:0], led[7]} : {led[0], led[7:1]};
                            default: ;
                        endcase
                    end
                end
                FAULT: begin
                    // A clear only counts once the fault level has gone away.
                    if (fault_clr && !fault) begin
                        state    <= NORMAL;
                        in_fault <= 1'b0;
                        mode_cur <= 2'd0;
                        led      <= 8'h00;
                        tick_cnt <= '0;
                        step_cnt <= '0;
                        phase    <= 1'b0;
                    end else if (step) begin
                        led   <= phase ? 8'h55 : 8'hAA;
                        phase <= ~phase;
                    end
                end
                default: state <= NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed vector table for the timed
// sequences, then random stimulus checked against a step-counting model.
module tb_led_pattern_sequencer;

    localparam int TICK_DIV   = 4;
    localparam int STEP_TICKS = 2;
    localparam int STEP_CYC   = TICK_DIV * STEP_TICKS;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode_req;
    logic       mode_valid;
    logic       mode_ready;
    logic       dir;
    logic       fault;
    logic       fault_clr;
    logic [7:0] led;
    logic [1:0] mode_cur;
    logic       in_fault;

    led_pattern_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .STEP_TICKS(STEP_TICKS),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode_req  (mode_req),
        .mode_valid(mode_valid),
        .mode_ready(mode_ready),
        .dir       (dir),
        .fault     (fault),
        .fault_clr (fault_clr),
        .led       (led),
        .mode_cur  (mode_cur),
        .in_fault  (in_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycles since the last restart, steps taken, chase position.
    bit         m_flt   = 1'b0;
    logic [1:0] m_mode  = 2'd0;
    int         m_cyc   = 0;
    int         m_steps = 0;
    int         m_pos   = 0;

    logic [10:0] exp_q[$];

    function automatic logic [7:0] model_led();
        if (m_flt) return (m_steps % 2 == 1) ? 8'hAA : 8'h55;
        case (m_mode)
            2'd0:    return 8'h00;
            2'd1:    return 8'hFF;
            2'd2:    return (m_steps % 2 == 1) ? 8'h00 : 8'hFF;
            default: return 8'(1 << m_pos);
        endcase
    endfunction

    task automatic model_update();
        if (reset) begin
            m_flt = 1'b0; m_mode = 2'd0; m_cyc = 0; m_steps = 0; m_pos = 0;
        end else if (!m_flt && fault) begin
            m_flt = 1'b1; m_cyc = 0; m_steps = 0;
        end else if (!m_flt && mode_valid) begin
            m_mode = mode_req; m_cyc = 0; m_steps = 0; m_pos = dir ? 0 : 7;
        end else if (m_flt && fault_clr && !fault) begin
            m_flt = 1'b0; m_mode = 2'd0; m_cyc = 0; m_steps = 0;
        end else begin
            m_cyc++;
            if (m_cyc % STEP_CYC == 0) begin
                m_steps++;
                if (!m_flt && m_mode == 2'd3) m_pos = dir ? (m_pos + 1) % 8 : (m_pos + 7) % 8;
            end
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic [1:0] q, input logic v,
                         input logic d, input logic f, input logic c);
        reset = r; mode_req = q; mode_valid = v; dir = d; fault = f; fault_clr = c;
        #1;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        string      name;
        logic       rst;
        logic [1:0] req;
        logic       valid;
        logic       d;
        logic       flt;
        logic       clr;
        int         idle;
        logic       exp_rdy;
        logic [7:0] exp_led;
        logic [1:0] exp_mode;
        logic       exp_flt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic rst, input logic [1:0] req,
                       input logic valid, input logic d, input logic flt, input logic clr,
                       input int idle, input logic exp_rdy, input logic [7:0] exp_led,
                       input logic [1:0] exp_mode, input logic exp_flt);
        vec_t v;
        v.name = name; v.rst = rst; v.req = req; v.valid = valid; v.d = d;
        v.flt = flt; v.clr = clr; v.idle = idle; v.exp_rdy = exp_rdy;
        v.exp_led = exp_led; v.exp_mode = exp_mode; v.exp_flt = exp_flt;
        vecs.push_back(v);
    endtask

    initial begin
        logic       flt_lvl;
        logic       dir_lvl;
        logic [10:0] exp_w;

        // Directed table: drive one cycle, idle for 'idle' cycles, then compare.
        add("idle50",      0, 2'd0, 0, 1, 0, 0, 49, 1, 8'h00, 2'd0, 0);
        add("blink_acc",   0, 2'd2, 1, 1, 0, 0, 0,  1, 8'hFF, 2'd2, 0);
        add("blink_s1",    0, 2'd0, 0, 1, 0, 0, 7,  1, 8'h00, 2'd2, 0);
        add("blink_s2",    0, 2'd0, 0, 1, 0, 0, 7,  1, 8'hFF, 2'd2, 0);
        add("blink_s3",    0, 2'd0, 0, 1, 0, 0, 7,  1, 8'h00, 2'd2, 0);
        add("chase_acc",   0, 2'd3, 1, 1, 0, 0, 0,  1, 8'h01, 2'd3, 0);
        for (int k = 1; k <= 10; k++)
            add($sformatf("chase_l%0d", k), 0, 2'd0, 0, 1, 0, 0, 7, 1, 8'(1 << (k % 8)), 2'd3, 0);
        for (int k = 1; k <= 6; k++)
            add($sformatf("chase_r%0d", k), 0, 2'd0, 0, 0, 0, 0, 7, 1, 8'(1 << ((10 - k) % 8)), 2'd3, 0);
        add("reset_mid",   1, 2'd0, 0, 0, 0, 0, 0,  1, 8'h00, 2'd0, 0);
        add("blink_after", 0, 2'd2, 1, 0, 0, 0, 0,  1, 8'hFF, 2'd2, 0);
        add("on_acc",      0, 2'd1, 1, 0, 0, 0, 0,  1, 8'hFF, 2'd1, 0);
        add("on_hold",     0, 2'd0, 0, 0, 0, 0, 2,  1, 8'hFF, 2'd1, 0);
        add("fault_req",   0, 2'd3, 1, 0, 1, 0, 0,  0, 8'h55, 2'd1, 1);
        add("fault_s1",    0, 2'd0, 0, 0, 0, 0, 7,  0, 8'hAA, 2'd1, 1);
        add("fault_s2",    0, 2'd0, 0, 0, 0, 0, 7,  0, 8'h55, 2'd1, 1);
        add("clr_blocked", 0, 2'd2, 1, 0, 1, 1, 0,  0, 8'h55, 2'd1, 1);
        add("clr_ok",      0, 2'd0, 0, 0, 0, 1, 0,  0, 8'h00, 2'd0, 0);
        add("on_after",    0, 2'd1, 1, 0, 0, 0, 0,  1, 8'hFF, 2'd1, 0);
        add("clr_normal",  0, 2'd0, 0, 0, 0, 1, 0,  1, 8'hFF, 2'd1, 0);

        // Reset held for three cycles.
        apply(1, 2'd0, 0, 1, 0, 0);
        repeat (3) clock_edge();
        check("rst_led", led, 8'h00);
        check("rst_mode", 8'(mode_cur), 8'h00);
        check("rst_fault", 8'(in_fault), 8'h00);
        check("rst_ready", 8'(mode_ready), 8'h01);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].req, vecs[i].valid, vecs[i].d, vecs[i].flt, vecs[i].clr);
            check({vecs[i].name, "_ready"}, 8'(mode_ready), 8'(vecs[i].exp_rdy));
            clock_edge();
            apply(0, 2'd0, 0, vecs[i].d, 0, 0);
            for (int j = 0; j < vecs[i].idle; j++) clock_edge();
            check({vecs[i].name, "_led"}, led, vecs[i].exp_led);
            check({vecs[i].name, "_mode"}, 8'(mode_cur), 8'(vecs[i].exp_mode));
            check({vecs[i].name, "_fault"}, 8'(in_fault), 8'(vecs[i].exp_flt));
        end

        // Random phase against the model.
        flt_lvl = 1'b0;
        dir_lvl = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 24) == 0) flt_lvl = ~flt_lvl;
            if ($urandom_range(0, 9) == 0)  dir_lvl = ~dir_lvl;
            apply(($urandom_range(0, 99) == 0), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 29) == 0), dir_lvl, flt_lvl,
                  ($urandom_range(0, 7) == 0));
            check("rand_ready", 8'(mode_ready), 8'(!m_flt && !fault));
            clock_edge();
            exp_q.push_back({model_led(), m_mode, m_flt});
            exp_w = exp_q.pop_front();
            check("rand_led", led, exp_w[10:3]);
            check("rand_mode", 8'(mode_cur), 8'(exp_w[2:1]));
            check("rand_fault", 8'(in_fault), 8'(exp_w[0]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
